add_sub_seq: RTL and testbench

Parametrised multi-cycle successor to the combinational add/subtract unit. It computes x+y or x−y over WIDTH bits, CHUNK bits per cycle, LSB chunk first. It adds a valid/ready handshake on both sides, per-transaction signed/unsigned saturation, and carry/overflow flags. It sits between operand issue and the ALU result stage, where a full-width single-cycle carry chain would miss timing.

---
 rtl/add_sub_seq.sv | 116 +++++++++++
 tb/tb_add_sub_seq.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/add_sub_seq.sv
// Multi-cycle add/subtract: WIDTH bits, CHUNK bits per cycle, LSB chunk first,
// with valid/ready handshakes, carry/overflow flags and optional saturation.
//
//   state | meaning
//   IDLE  | waiting for operands, in_ready=1
//   BUSY  | adding one chunk per cycle
//   DONE  | result valid, held until out_ready
module add_sub_seq #(
   parameter int WIDTH = 32,
   parameter int CHUNK = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] x,
   input  logic [WIDTH-1:0] y,
   input  logic             sign,
   input  logic             signed_op,
   input  logic             sat,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] z,
   output logic             carry,
   output logic             overflow,
   output logic             busy
);

   localparam int N  = WIDTH / CHUNK;
   localparam int CW = (N > 1) ? $clog2(N) : 1;
   localparam logic [CW-1:0] LAST = CW'(N - 1);

   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

   state_t                  state, state_nxt;
   logic [N-1:0][CHUNK-1:0] xa, yb, acc, res_full;
   logic [CW-1:0]           cnt;
   logic                    run_c, op_sub, op_signed, op_sat;
   logic [CHUNK:0]          csum;
   logic                    cin_msb, ovf_nxt, accept, last;
   logic [WIDTH-1:0]        z_nxt;

   assign in_ready  = (state == IDLE) || ((state == DONE) && out_ready);
   assign out_valid = (state == DONE);
   assign busy      = (state != IDLE);
   assign accept    = in_valid && in_ready;
   assign last      = (cnt == LAST);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (in_valid) state_nxt = BUSY;
         BUSY:    if (last) state_nxt = DONE;
         DONE:    if (out_ready) state_nxt = in_valid ? BUSY : IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Chunk adder; on the last chunk the MSB carry-in is recovered from the
   // sum bit, so overflow and saturation resolve in the same cycle.
   always_comb begin
      csum          = {1'b0, xa[cnt]} + {1'b0, yb[cnt]} + {{CHUNK{1'b0}}, run_c};
      res_full      = acc;
      res_full[cnt] = csum[CHUNK-1:0];
      cin_msb       = xa[N-1][CHUNK-1] ^ yb[N-1][CHUNK-1] ^ csum[CHUNK-1];
      if (op_signed) ovf_nxt = cin_msb ^ csum[CHUNK];
      else           ovf_nxt = op_sub ? ~csum[CHUNK] : csum[CHUNK];
      z_nxt = res_full;
      if (op_sat && ovf_nxt) begin
         if (op_signed)
            z_nxt = xa[N-1][CHUNK-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
         else
            z_nxt = op_sub ? '0 : '1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         xa        <= '0;
         yb        <= '0;
         acc       <= '0;
         cnt       <= '0;
         run_c     <= 1'b0;
         op_sub    <= 1'b0;
         op_signed <= 1'b0;
         op_sat    <= 1'b0;
         z         <= '0;
         carry     <= 1'b0;
         overflow  <= 1'b0;
      end else if (accept) begin
         xa        <= x;
         yb        <= y ^ {WIDTH{sign}};
         op_sub    <= sign;
         op_signed <= signed_op;
         op_sat    <= sat;
         run_c     <= sign;
         cnt       <= '0;
      end else if (state == BUSY) begin
         acc[cnt] <= csum[CHUNK-1:0];
         run_c    <= csum[CHUNK];
         if (last) begin
            z        <= z_nxt;
            carry    <= csum[CHUNK];
            overflow <= ovf_nxt;
         end else begin
            cnt <= cnt + 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_add_sub_seq.sv
// Directed-vector bench for add_sub_seq (32/8 instance) plus an N=1 instance.
module tb_add_sub_seq;

   typedef struct packed {
      logic [31:0] x;
      logic [31:0] y;
      logic        sign;
      logic        so;
      logic        sat;
      logic [31:0] ez;
      logic        ec;
      logic        eo;
   } vec_t;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid, in_ready, sign, signed_op, sat, out_valid, out_ready;
   logic        carry, overflow, busy;
   logic [31:0] x, y, z;

   logic        in_valid1, in_ready1, sign1, signed_op1, sat1, out_valid1, out_ready1;
   logic        carry1, overflow1, busy1;
   logic [31:0] x1, y1, z1;

   int n_cmp = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   add_sub_seq #(.WIDTH(32), .CHUNK(8)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .x(x), .y(y), .sign(sign), .signed_op(signed_op), .sat(sat),
      .out_valid(out_valid), .out_ready(out_ready), .z(z), .carry(carry),
      .overflow(overflow), .busy(busy)
   );

   add_sub_seq #(.WIDTH(32), .CHUNK(32)) dut1 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid1), .in_ready(in_ready1),
      .x(x1), .y(y1), .sign(sign1), .signed_op(signed_op1), .sat(sat1),
      .out_valid(out_valid1), .out_ready(out_ready1), .z(z1), .carry(carry1),
      .overflow(overflow1), .busy(busy1)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Whole-width reference for random traffic.
   function automatic logic [33:0] model(input logic [31:0] a, input logic [31:0] b,
                                         input logic s, input logic so, input logic st);
      logic [31:0] bb, rz;
      logic [32:0] r;
      logic        c, o;
      bb = s ? ~b : b;
      r  = {1'b0, a} + {1'b0, bb} + {32'd0, s};
      c  = r[32];
      rz = r[31:0];
      if (so) o = (a[31] == bb[31]) && (rz[31] != a[31]);
      else    o = s ? !c : c;
      if (st && o) begin
         if (so) rz = a[31] ? 32'h8000_0000 : 32'h7FFF_FFFF;
         else    rz = s ? 32'h0 : 32'hFFFF_FFFF;
      end
      return {rz, c, o};
   endfunction

   // Issue one op and return with outputs sampled just after out_valid rises.
   task automatic run_op(input vec_t v, output int lat);
      @(negedge clk);
      x = v.x; y = v.y; sign = v.sign; signed_op = v.so; sat = v.sat; in_valid = 1'b1;
      @(posedge clk);
      #1 in_valid = 1'b0;
      x = 32'hDEAD_BEEF; y = 32'hDEAD_BEEF;
      lat = 0;
      while (lat < 20) begin
         @(posedge clk);
         #1 lat++;
         if (out_valid) break;
      end
   endtask

   task automatic consume();
      @(negedge clk);
      out_ready = 1'b1;
      @(posedge clk);
      #1 out_ready = 1'b0;
      chk("ov_drop", {31'd0, out_valid}, 32'd0);
   endtask

   vec_t vecs[13];

   initial begin
      int          lat, seen, ic, rc, last_cyc;
      logic [31:0] zh;
      logic        acc_now;
      logic [31:0] rx[10], ry[10];
      logic        rs[10], rso[10], rsat[10];
      logic [33:0] m;

      vecs[0]  = '{32'hFFFF_FFFF, 32'h1,         1'b0, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b1};
      vecs[1]  = '{32'h7FFF_FFFF, 32'h1,         1'b0, 1'b1, 1'b1, 32'h7FFF_FFFF, 1'b0, 1'b1};
      vecs[2]  = '{32'h7FFF_FFFF, 32'h1,         1'b0, 1'b1, 1'b0, 32'h8000_0000, 1'b0, 1'b1};
      vecs[3]  = '{32'h3,         32'h5,         1'b1, 1'b0, 1'b1, 32'h0000_0000, 1'b0, 1'b1};
      vecs[4]  = '{32'h3,         32'h5,         1'b1, 1'b1, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0};
      vecs[5]  = '{32'h8000_0000, 32'h1,         1'b1, 1'b1, 1'b1, 32'h8000_0000, 1'b1, 1'b1};
      vecs[6]  = '{32'h8000_0000, 32'h1,         1'b1, 1'b1, 1'b0, 32'h7FFF_FFFF, 1'b1, 1'b1};
      vecs[7]  = '{32'h1234_5678, 32'h1111_1111, 1'b0, 1'b0, 1'b1, 32'h2345_6789, 1'b0, 1'b0};
      vecs[8]  = '{32'h5,         32'h3,         1'b1, 1'b0, 1'b1, 32'h0000_0002, 1'b1, 1'b0};
      vecs[9]  = '{32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0, 1'b1, 32'hFFFF_FFFF, 1'b1, 1'b1};
      vecs[10] = '{32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b1, 1'b1, 32'h8000_0000, 1'b1, 1'b1};
      vecs[11] = '{32'hFFFF_FFFF, 32'h1,         1'b0, 1'b1, 1'b1, 32'h0000_0000, 1'b1, 1'b0};
      vecs[12] = '{32'h0000_FFFF, 32'h0000_FFFF, 1'b0, 1'b0, 1'b0, 32'h0001_FFFE, 1'b0, 1'b0};

      rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
      x = '0; y = '0; sign = 1'b0; signed_op = 1'b0; sat = 1'b0;
      in_valid1 = 1'b0; out_ready1 = 1'b1; x1 = '0; y1 = '0;
      sign1 = 1'b0; signed_op1 = 1'b0; sat1 = 1'b0;
      #23;
      chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
      chk("rst_busy", {31'd0, busy}, 32'd0);
      chk("rst_z", z, 32'd0);
      chk("rst_flags", {30'd0, carry, overflow}, 32'd0);
      @(negedge clk) rst_n = 1'b1;
      #1 chk("rst_in_ready", {31'd0, in_ready}, 32'd1);

      for (int i = 0; i < 13; i++) begin
         run_op(vecs[i], lat);
         chk($sformatf("v%0d_latency", i), lat, 32'd4);
         chk($sformatf("v%0d_z", i), z, vecs[i].ez);
         chk($sformatf("v%0d_carry", i), {31'd0, carry}, {31'd0, vecs[i].ec});
         chk($sformatf("v%0d_overflow", i), {31'd0, overflow}, {31'd0, vecs[i].eo});
         consume();
         if (i == 0) chk("idle_hold_z", z, vecs[0].ez);
      end

      // Backpressure in DONE, then back-to-back accept on the releasing edge.
      run_op(vecs[1], lat);
      zh = z;
      for (int k = 0; k < 3; k++) begin
         @(posedge clk);
         #1;
         chk("bp_out_valid", {31'd0, out_valid}, 32'd1);
         chk("bp_in_ready", {31'd0, in_ready}, 32'd0);
         chk("bp_z", z, zh);
         chk("bp_flags", {30'd0, carry, overflow}, {30'd0, vecs[1].ec, vecs[1].eo});
      end
      @(negedge clk);
      out_ready = 1'b1; in_valid = 1'b1;
      x = 32'h5; y = 32'h3; sign = 1'b1; signed_op = 1'b0; sat = 1'b1;
      #1 chk("b2b_in_ready", {31'd0, in_ready}, 32'd1);
      @(posedge clk);
      #1 in_valid = 1'b0; out_ready = 1'b0; x = '0; y = '0;
      chk("b2b_out_valid_drop", {31'd0, out_valid}, 32'd0);
      chk("b2b_busy", {31'd0, busy}, 32'd1);
      lat = 0;
      while (lat < 20) begin
         @(posedge clk);
         #1 lat++;
         if (out_valid) break;
      end
      chk("b2b_latency", lat, 32'd4);
      chk("b2b_z", z, 32'h2);
      chk("b2b_flags", {30'd0, carry, overflow}, 32'b10);
      consume();

      // Reset after two chunks abandons the operation.
      @(negedge clk);
      x = 32'hFFFF_FFFF; y = 32'h1; sign = 1'b0; signed_op = 1'b0; sat = 1'b0; in_valid = 1'b1;
      @(posedge clk);
      #1 in_valid = 1'b0;
      @(posedge clk);
      @(posedge clk);
      #1 rst_n = 1'b0;
      #1;
      chk("midrst_busy", {31'd0, busy}, 32'd0);
      chk("midrst_out_valid", {31'd0, out_valid}, 32'd0);
      chk("midrst_z", z, 32'd0);
      chk("midrst_flags", {30'd0, carry, overflow}, 32'd0);
      @(negedge clk) rst_n = 1'b1;
      seen = 0;
      for (int k = 0; k < 8; k++) begin
         @(posedge clk);
         #1 if (out_valid || busy) seen++;
      end
      chk("midrst_no_result", seen, 32'd0);
      chk("midrst_in_ready", {31'd0, in_ready}, 32'd1);

      // Sustained back-to-back random traffic: one result per 5 cycles.
      for (int i = 0; i < 10; i++) begin
         rx[i] = $urandom; ry[i] = $urandom;
         rs[i] = 1'($urandom_range(0, 1));
         rso[i] = 1'($urandom_range(0, 1));
         rsat[i] = 1'($urandom_range(0, 1));
      end
      rx[0] = 32'h7FFF_FFF0; ry[0] = 32'h20; rso[0] = 1'b1; rsat[0] = 1'b1; rs[0] = 1'b0;
      ic = 0; rc = 0; last_cyc = 0;
      out_ready = 1'b1;
      for (int cyc = 0; cyc < 200 && rc < 10; cyc++) begin
         @(negedge clk);
         if (out_valid) begin
            m = model(rx[rc], ry[rc], rs[rc], rso[rc], rsat[rc]);
            chk($sformatf("rnd%0d_z", rc), z, m[33:2]);
            chk($sformatf("rnd%0d_flags", rc), {30'd0, carry, overflow}, {30'd0, m[1:0]});
            if (rc > 0) chk($sformatf("rnd%0d_period", rc), cyc - last_cyc, 32'd5);
            last_cyc = cyc;
            rc++;
         end
         if (ic < 10) begin
            x = rx[ic]; y = ry[ic]; sign = rs[ic]; signed_op = rso[ic]; sat = rsat[ic];
            in_valid = 1'b1;
         end else begin
            in_valid = 1'b0;
         end
         acc_now = in_valid && in_ready;
         @(posedge clk);
         if (acc_now) ic++;
      end
      chk("rnd_count", rc, 32'd10);
      out_ready = 1'b0; in_valid = 1'b0;

      // N=1 instance: single BUSY cycle.
      @(negedge clk);
      x1 = 32'h1234_5678; y1 = 32'h1111_1111; sign1 = 1'b0; signed_op1 = 1'b0; sat1 = 1'b0;
      in_valid1 = 1'b1; out_ready1 = 1'b0;
      @(posedge clk);
      #1 in_valid1 = 1'b0;
      chk("n1_busy", {31'd0, busy1}, 32'd1);
      chk("n1_early_valid", {31'd0, out_valid1}, 32'd0);
      @(posedge clk);
      #1;
      chk("n1_out_valid", {31'd0, out_valid1}, 32'd1);
      chk("n1_z", z1, 32'h2345_6789);
      chk("n1_flags", {30'd0, carry1, overflow1}, 32'd0);
      @(negedge clk);
      out_ready1 = 1'b1; in_valid1 = 1'b1;
      x1 = 32'hFFFF_FFFF; y1 = 32'h1; sat1 = 1'b1;
      @(posedge clk);
      #1 in_valid1 = 1'b0;
      @(posedge clk);
      #1;
      chk("n1_sat_valid", {31'd0, out_valid1}, 32'd1);
      chk("n1_sat_z", z1, 32'hFFFF_FFFF);
      chk("n1_sat_flags", {30'd0, carry1, overflow1}, 32'b11);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not complete");
      $fatal(1, "timeout");
   end

endmodule
